// File: rtl/adc_cfg_sequencer.sv
// Walks a small table of ADC configuration words through the SPI4ADC engine,
// one launch per entry, with timeout supervision and an inter-transfer gap.
module adc_cfg_sequencer #(
  parameter int unsigned N_ENTRIES  = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [35:0]       cfg_wdata,
  input  logic [ADDR_W:0]   num_entries,
  input  logic              start,
  input  logic              abort,
  output logic [31:0]       spi_data,
  output logic              spi_cpol,
  output logic              spi_cpha,
  output logic              ps_A0,
  output logic              ps_A1,
  output logic              spi_start,
  input  logic              spi_status,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] cur_index
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] last_d;
  logic [ADDR_W:0]   n_clamp;
  logic [TW-1:0]     tcnt_q;
  logic [GW-1:0]     gcnt_q;
  logic              timed_out;
  logic              error_q;
  logic [ADDR_W-1:0] cur_index_q;
  logic [35:0]       cfg_q;
  logic [35:0]       cfg_tab [N_ENTRIES];

  always_comb begin
    n_clamp = num_entries;
    if (num_entries > (ADDR_W + 1)'(N_ENTRIES)) begin
      n_clamp = (ADDR_W + 1)'(N_ENTRIES);
    end
    last_d = ADDR_W'(n_clamp - 1'b1);
  end

  assign timed_out = (tcnt_q >= TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = (num_entries == '0) ? S_FINISH : S_LOAD;
      S_LOAD:      state_d = S_START;
      S_START:     state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!spi_status)    state_d = S_WAIT_DONE;
        else if (timed_out) state_d = S_ERROR;
      end
      S_WAIT_DONE: begin
        if (spi_status)     state_d = S_GAP;
        else if (timed_out) state_d = S_ERROR;
      end
      S_GAP: begin
        if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = (idx_q == last_q) ? S_FINISH : S_LOAD;
        end
      end
      S_FINISH:    state_d = S_IDLE;
      S_ERROR:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // abort overrides every exit, including a pending timeout
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
      error_q     <= 1'b0;
      cur_index_q <= '0;
      cfg_q       <= '0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q)        tcnt_q <= '0;
      else if (tcnt_q != TW'(TIMEOUT)) tcnt_q <= tcnt_q + 1'b1;

      if (state_q == S_GAP && state_d == S_GAP) gcnt_q <= gcnt_q + 1'b1;
      else                                      gcnt_q <= '0;

      if (state_q == S_IDLE && start) begin
        idx_q       <= '0;
        last_q      <= last_d;
        error_q     <= 1'b0;
        cur_index_q <= '0;
      end

      if (state_q == S_LOAD) begin
        cfg_q       <= cfg_tab[idx_q];
        cur_index_q <= idx_q;
      end

      if (state_q == S_GAP && state_d == S_LOAD) idx_q <= idx_q + 1'b1;

      if (state_d == S_ERROR) error_q <= 1'b1;
    end
  end

  // Table storage is deliberately left unreset so a reset does not force a reload.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) cfg_tab[cfg_addr] <= cfg_wdata;
  end

  assign spi_data  = cfg_q[31:0];
  assign spi_cpol  = cfg_q[32];
  assign spi_cpha  = cfg_q[33];
  assign ps_A0     = cfg_q[34];
  assign ps_A1     = cfg_q[35];
  assign spi_start = (state_q == S_START) && !abort;
  assign busy      = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_WAIT_ACK) ||
                     (state_q == S_WAIT_DONE) || (state_q == S_GAP);
  assign done      = (state_q == S_FINISH);
  assign error     = error_q;
  assign cur_index = cur_index_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer with a behavioural SPI4ADC status model.
module tb_adc_cfg_sequencer;

  localparam int unsigned N   = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned TO  = 64;
  localparam int unsigned GAP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [35:0]   cfg_wdata = '0;
  logic [AW:0]   num_entries = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   spi_data;
  logic          spi_cpol, spi_cpha, ps_A0, ps_A1, spi_start;
  logic          spi_status;
  logic          busy, done, error;
  logic [AW-1:0] cur_index;

  adc_cfg_sequencer #(
    .N_ENTRIES (N),
    .ADDR_W    (AW),
    .TIMEOUT   (TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .num_entries(num_entries),
    .start      (start),
    .abort      (abort),
    .spi_data   (spi_data),
    .spi_cpol   (spi_cpol),
    .spi_cpha   (spi_cpha),
    .ps_A0      (ps_A0),
    .ps_A1      (ps_A1),
    .spi_start  (spi_start),
    .spi_status (spi_status),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cur_index  (cur_index)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int last_start = -1;
  int exp_idx = 0;
  int model_limit = 99;
  bit busy_seen = 1'b0;
  bit model_en = 1'b1;
  logic [35:0] exp_tab [N];

  typedef struct {
    int n;
    int xfers;
    int dones;
    bit busy_exp;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse/launch monitor
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (spi_start === 1'b1) begin
        start_cnt++;
        if (last_start >= 0) check("start_spacing", 64'((cyc - last_start) >= int'(GAP + 2)), 64'd1);
        last_start = cyc;
      end
    end
  end

  // SPI4ADC status model: busy for a short frame after each launch
  initial begin
    spi_status = 1'b1;
    forever begin
      @(negedge clk);
      if (model_en && spi_start === 1'b1 && exp_idx < model_limit) begin
        @(negedge clk);
        spi_status = 1'b0;
        check("cfg_word", {ps_A1, ps_A0, spi_cpha, spi_cpol, spi_data}, exp_tab[exp_idx]);
        check("cur_index", cur_index, exp_idx);
        exp_idx++;
        repeat (3) @(negedge clk);
        spi_status = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_run();
    start_cnt  = 0;
    done_cnt   = 0;
    exp_idx    = 0;
    busy_seen  = 1'b0;
    last_start = -1;
  endtask

  task automatic wait_end(input string name);
    int k = 0;
    while (done_cnt == 0 && error !== 1'b1 && k < 3000) begin
      tick();
      k++;
    end
    check({name, "_bound"}, 64'(k < 3000), 64'd1);
    repeat (8) tick();
  endtask

  task automatic wr(input int a, input logic [35:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic launch(input int n);
    num_entries = (AW + 1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    int d;

    exp_tab[0] = 36'hB_F800_0001;
    exp_tab[1] = 36'h5_F400_00FF;
    for (int i = 2; i < int'(N); i++) exp_tab[i] = {4'(i * 5 + 1), 32'h3C00_0000 | 32'(i)};

    vecs[0] = '{n: 2,  xfers: 2, dones: 1, busy_exp: 1'b1};
    vecs[1] = '{n: 1,  xfers: 1, dones: 1, busy_exp: 1'b1};
    vecs[2] = '{n: 8,  xfers: 8, dones: 1, busy_exp: 1'b1};
    vecs[3] = '{n: 15, xfers: 8, dones: 1, busy_exp: 1'b1};
    vecs[4] = '{n: 0,  xfers: 0, dones: 1, busy_exp: 1'b0};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {spi_data, spi_cpol, spi_cpha, ps_A0, ps_A1, spi_start, busy, done, error, cur_index}, '0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < int'(N); i++) wr(i, exp_tab[i]);

    // start and abort together in IDLE: start wins
    clear_run();
    abort = 1'b1;
    launch(1);
    abort = 1'b0;
    check("start_beats_abort", busy, 1'b1);
    wait_end("start_abort");
    check("start_abort_xfers", start_cnt, 1);

    for (int i = 0; i < 5; i++) begin
      clear_run();
      launch(vecs[i].n);
      wait_end($sformatf("vec%0d", i));
      check($sformatf("vec%0d_xfers", i), start_cnt, vecs[i].xfers);
      check($sformatf("vec%0d_dones", i), done_cnt, vecs[i].dones);
      check($sformatf("vec%0d_busy_seen", i), busy_seen, vecs[i].busy_exp);
      check($sformatf("vec%0d_error", i), error, 1'b0);
      check($sformatf("vec%0d_busy_end", i), busy, 1'b0);
    end

    // Table write while busy must be ignored
    clear_run();
    launch(15);
    repeat (3) tick();
    wr(2, 36'h0_DEAD_BEEF);
    wait_end("we_busy");
    check("we_busy_xfers", start_cnt, 8);
    check("we_busy_dones", done_cnt, 1);

    // Timeout in WAIT_ACK on the second entry
    clear_run();
    model_limit = 1;
    launch(3);
    k = 0;
    while (start_cnt < 2 && k < 500) begin tick(); k++; end
    check("to_second_launch", 64'(k < 500), 64'd1);
    k = 0;
    while (error !== 1'b1 && k < int'(TO) + 20) begin tick(); k++; end
    d = cyc - last_start;
    check("to_delay_window", 64'(d >= int'(TO) && d <= int'(TO) + 2), 64'd1);
    check("to_error", error, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_cur_index", cur_index, 3'd1);
    repeat (3) tick();
    check("to_error_sticky", error, 1'b1);
    check("to_no_done", done_cnt, 0);
    model_limit = 99;
    launch(0);
    check("zero_done_next_cycle", done, 1'b1);
    check("start_clears_error", error, 1'b0);
    check("start_clears_index", cur_index, 3'd0);
    tick();
    check("zero_done_one_cycle", done, 1'b0);

    // Abort during entry 3 of 8
    clear_run();
    launch(8);
    k = 0;
    while (start_cnt < 4 && k < 500) begin tick(); k++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_spi_start", spi_start, 1'b0);
    repeat (40) tick();
    check("abort_xfers", start_cnt, 4);
    check("abort_cfg_hold", {ps_A1, ps_A0, spi_cpha, spi_cpol, spi_data}, exp_tab[3]);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_error", error, 1'b0);

    // Asynchronous reset in WAIT_DONE, then full replay
    clear_run();
    launch(8);
    k = 0;
    while (start_cnt < 2 && k < 500) begin tick(); k++; end
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {spi_data, spi_cpol, spi_cpha, ps_A0, ps_A1, spi_start, busy, done, error, cur_index}, '0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    clear_run();
    launch(8);
    wait_end("replay");
    check("replay_xfers", start_cnt, 8);
    check("replay_dones", done_cnt, 1);
    check("replay_error", error, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_cfg_sequencer.md
Name: adc_cfg_sequencer

Overview:
Sequences a table of ADC configuration words through the SPI4ADC serial engine. Software or a boot FSM loads up to N_ENTRIES entries (32-bit word, CPOL, CPHA, A1/A0 chip select) into an internal register file, then pulses start. The sequencer issues each entry in order, waits for the engine to complete, inserts an inter-transfer gap, and reports done, error and progress. It sits between the system control logic and SPI4ADC, and is the sole driver of SPI4ADC's configuration inputs.

Parameters:
N_ENTRIES, 8, depth of the configuration table (power of two, 2..16)
ADDR_W, 3, table address width, equal to log2(N_ENTRIES)
TIMEOUT, 4096, maximum clk cycles allowed in each wait state before an error is flagged
GAP_CYCLES, 16, idle clk cycles between consecutive transfers (minimum 1)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  ADDR_W  table write address
cfg_wdata  in  36  entry {A1,A0,cpha,cpol,data[31:0]}, bits [35:32]={A1,A0,cpha,cpol}
num_entries  in  ADDR_W+1  number of entries to send, counted from address 0
start  in  1  one-cycle request to run the sequence
abort  in  1  one-cycle request to stop the sequence
spi_data  out  32  word to SPI4ADC
spi_cpol  out  1  clock polarity to SPI4ADC
spi_cpha  out  1  clock phase to SPI4ADC
ps_A0  out  1  chip-select address bit 0 to SPI4ADC
ps_A1  out  1  chip-select address bit 1 to SPI4ADC
spi_start  out  1  one-cycle launch pulse to SPI4ADC
spi_status  in  1  SPI4ADC status: 1 = idle/complete, 0 = transfer in progress
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when all entries have been sent
error  out  1  sticky timeout flag
cur_index  out  ADDR_W  index of the entry being sent, or of the failing entry

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; table contents are not reset.
- Table writes are accepted only in IDLE. cfg_we while busy is ignored.
- num_entries is sampled on start. Values above N_ENTRIES are clamped to N_ENTRIES.
- start with num_entries=0: done pulses in the next cycle, no transfer occurs, busy stays 0.
- start while busy is ignored. start clears error and cur_index.
- States and transitions:
  - IDLE: on start (num_entries>0) go to LOAD; busy=1, idx=0.
  - LOAD: register table[idx] onto spi_data, spi_cpol, spi_cpha, ps_A0 and ps_A1; cur_index=idx. Go to START.
  - START: spi_start=1 for exactly one cycle. Go to WAIT_ACK. The timeout counter resets to 0 on entry to each wait state.
  - WAIT_ACK: wait for spi_status=0, then go to WAIT_DONE. If TIMEOUT cycles elapse first, go to ERROR.
  - WAIT_DONE: wait for spi_status=1, then go to GAP. If TIMEOUT cycles elapse first, go to ERROR.
  - GAP: count GAP_CYCLES. Then, if idx=num_entries-1, go to FINISH; otherwise increment idx and go to LOAD.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
  - ERROR: error=1 (sticky), busy=0, cur_index holds the failing index, go to IDLE. done is not pulsed.
- Configuration outputs change only in LOAD. They stay stable from LOAD through the end of GAP, and hold their last value while idle.
- abort in any non-IDLE state: go to IDLE on the next edge. busy=0; no done or error; spi_start is forced to 0. An in-flight SPI frame is not cut short.
- abort and start in the same cycle in IDLE: start wins.
- Latency: start to first spi_start is 2 cycles (LOAD, START). Per entry, the overhead beyond the SPI frame is 2+GAP_CYCLES cycles plus the status round-trip.
- Timeout counter width is clog2(TIMEOUT+1). It saturates and does not wrap.

Test Plan:
- Load entry 0={A1=1,A0=0,cpha=1,cpol=1,0xF8000001} and entry 1={A1=0,A0=1,cpha=0,cpol=1,0xF40000FF}; num_entries=2; start; model SPI4ADC status -> two spi_start pulses; outputs match each entry while spi_status=0; transfer starts are spaced by at least GAP_CYCLES+2; single done pulse; error=0.
- num_entries=0, start -> done pulses 1 cycle later; spi_start never asserts; busy stays 0.
- spi_status held at 1 after spi_start -> error=1 after TIMEOUT cycles in WAIT_ACK; cur_index=failing index; busy=0; no done. A following start clears error.
- abort during entry 3 of 8 -> IDLE next cycle; busy=0; no further spi_start; configuration outputs hold entry 3.
- rst asserted mid-WAIT_DONE -> all outputs 0 immediately (asynchronous); after release, start replays the table from index 0 with the table intact.
- num_entries=15 with N_ENTRIES=8, plus cfg_we while busy -> exactly 8 transfers are sent; table contents are unchanged by the ignored write.
